// File: rtl/ff_synchronizer.sv
// ff_synchronizer
// Multi-bit flip-flop chain synchroniser for asynchronous level signals
// entering the dest_clk domain. Each bit is carried by its own chain of
// STAGES flops; bits are independent and no cross-bit coherency is implied,
// so multi-bit values must be Gray-coded or quasi-static at the source.
// A history register behind the final stage yields single-cycle rise/fall
// pulses of the synchronised level.

module ff_synchronizer #(
  parameter int              WIDTH     = 1,
  parameter int              STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             dest_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
);

  // Chain depth below 2 gives no metastability protection; above 8 is
  // pointless latency. Either is a configuration mistake, caught at build.
  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("ff_synchronizer: STAGES=%0d is outside the legal range 2..8", STAGES);
  end

  // sync_chain[0] is the capture flop fed directly from d; sync_chain[STAGES-1]
  // drives q. The attribute keeps the chain flops placed adjacently and
  // excludes them from retiming so MTBF is not degraded.
  // NOTE: the declaration initialisers are the power-up values (FPGA
  // configuration init). They make the block usable without ever pulsing
  // rst; the synchronous reset below remains the functional reset path.
  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0][WIDTH-1:0] sync_chain = {STAGES{RESET_VAL}};

  // Previous value of q, used only for edge detection. It is a plain
  // same-domain register, so it carries no synchroniser attribute.
  logic [WIDTH-1:0] q_prev = RESET_VAL;

  // Shift the chain one stage per cycle; reset flushes any in-flight values.
  // NOTE: all state is updated with non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would collapse
  // the chain into a single flop.
  always_ff @(posedge dest_clk) begin
    if (rst) begin
      sync_chain <= {STAGES{RESET_VAL}};
    end else begin
      sync_chain <= {sync_chain[STAGES-2:0], d};
    end
  end

  // Track the last synchronised level; reset loads RESET_VAL so that the
  // output and its history agree and no pulse is produced on reset exit.
  always_ff @(posedge dest_clk) begin
    if (rst) begin
      q_prev <= RESET_VAL;
    end else begin
      q_prev <= q;
    end
  end

  // Outputs come from registers only, so the pulses are glitch-free and
  // nothing sits between d and the capture flop.
  assign q      = sync_chain[STAGES-1];
  assign q_rise = q & ~q_prev;
  assign q_fall = ~q & q_prev;

endmodule

// File: tb/tb_ff_synchronizer.sv
// tb_ff_synchronizer
// Self-checking bench for ff_synchronizer (WIDTH=4, STAGES=3, mixed
// RESET_VAL). A reference model predicts q/q_rise/q_fall after every rising
// edge from a sliding window of captured samples and pushes the prediction
// into a scoreboard queue; an independent monitor pops and compares on the
// falling edge.

module tb_ff_synchronizer;

  localparam int             W  = 4;
  localparam int             S  = 3;
  localparam logic [W-1:0]   RV = 4'b1001;

  logic         dest_clk = 1'b0;
  logic         rst      = 1'b1;
  logic [W-1:0] d        = '0;
  logic [W-1:0] q, q_rise, q_fall;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         r;
  } samp_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  samp_t        hist[$];
  exp_t         sb_q[$];
  logic [W-1:0] last_q = RV;

  ff_synchronizer #(
    .WIDTH     (W),
    .STAGES    (S),
    .RESET_VAL (RV)
  ) dut (
    .dest_clk (dest_clk),
    .rst      (rst),
    .d        (d),
    .q        (q),
    .q_rise   (q_rise),
    .q_fall   (q_fall)
  );

  always #5 dest_clk = ~dest_clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after an edge, q equals the value captured S-1 edges
  // earlier unless any reset fell inside that S-edge window, in which case it
  // is RV. The history value is the previous expected q, or RV on a reset edge.
  always @(posedge dest_clk) begin
    exp_t         e;
    logic [W-1:0] prev;
    bit           any_rst;
    hist.push_back('{d: d, r: rst});
    if (hist.size() > S) void'(hist.pop_front());
    any_rst = 1'b0;
    foreach (hist[i]) if (hist[i].r) any_rst = 1'b1;
    e.q    = any_rst ? RV : hist[0].d;
    prev   = hist[hist.size()-1].r ? RV : last_q;
    e.rise = e.q & ~prev;
    e.fall = ~e.q & prev;
    last_q = e.q;
    sb_q.push_back(e);
  end

  // Monitor: one expected entry per edge, compared away from the active edge.
  always @(negedge dest_clk) begin
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got no expectation, expected one at t=%0t", $time);
    end else begin
      e = sb_q.pop_front();
      check("q",      q,      e.q);
      check("q_rise", q_rise, e.rise);
      check("q_fall", q_fall, e.fall);
    end
  end

  // Wait for the next rising edge, then change inputs off-grid by off time units.
  task automatic drive(input logic [W-1:0] dv, input logic rv, input int off);
    @(posedge dest_clk);
    #off;
    d   = dv;
    rst = rv;
  endtask

  initial begin
    // The model treats power-up as if a reset had just flushed the chain.
    for (int i = 0; i < S; i++) hist.push_back('{d: '0, r: 1'b1});

    // Power-up state before any clock edge.
    #2;
    check("pwrup_q",      q,      RV);
    check("pwrup_q_rise", q_rise, '0);
    check("pwrup_q_fall", q_fall, '0);

    // Reset held for three edges, then released with d=all ones held.
    repeat (2) drive('0, 1'b1, 2);
    drive('1, 1'b0, 2);
    repeat (6) drive('1, 1'b0, 2);

    // Consecutive complementary patterns.
    drive(4'b1010, 1'b0, 2);
    drive(4'b0101, 1'b0, 2);
    repeat (5) drive(4'b0101, 1'b0, 2);

    // Alternating every cycle: rise and fall must alternate, never coincide.
    for (int i = 0; i < 20; i++) drive((i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0, 2);
    repeat (5) drive('0, 1'b0, 2);

    // Mid-flight reset: change, then reset one edge later while it is in the pipe.
    drive(4'b0110, 1'b0, 2);
    drive(4'b0110, 1'b1, 2);
    repeat (6) drive(4'b0110, 1'b0, 2);

    // Reset with d differing from RV: no pulse on exit, only after propagation.
    drive(4'b0110, 1'b1, 3);
    repeat (6) drive(4'b0110, 1'b0, 3);

    // Random off-grid changes held for at least two periods, occasional reset.
    begin
      int cyc;
      cyc = 0;
      while (cyc < 10000) begin
        logic [W-1:0] v;
        int           hold;
        int           off;
        v    = W'($urandom);
        hold = $urandom_range(2, 6);
        off  = $urandom_range(1, 9);
        drive(v, ($urandom_range(0, 299) == 0), off);
        for (int k = 1; k < hold; k++) drive(v, 1'b0, off);
        cyc += hold;
      end
    end

    repeat (S + 2) drive(d, 1'b0, 2);
    @(negedge dest_clk);
    #1;
    check("sb_drain", W'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ff_synchronizer.md
# ff_synchronizer

Multi-bit flip-flop chain synchroniser. It brings asynchronous level signals into the `dest_clk` domain, for example:
- an external reset request before the ADF4158 controller acts on it;
- a device status pin such as MUXOUT.

It also produces per-bit rise/fall pulses of the synchronised value so that downstream logic needs no separate edge detector. Each bit is synchronised independently. The block gives no coherency guarantee across bits; multi-bit buses must be Gray-coded or quasi-static upstream.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent bits synchronised.
- `STAGES`, default 2: flip-flops per bit in the chain. Legal range is 2..8; any other value is an elaboration error.
- `RESET_VAL`, default all zeros ([WIDTH-1:0]): value loaded into every stage, and into the history register, on reset.

Ports:
- `dest_clk`  in   1: destination clock. All state updates on its rising edge.
- `rst`  in   1: reset. One clock; reset is synchronous and active-high. Assume `rst` is already synchronous to `dest_clk`.
- `d`  in   WIDTH: asynchronous input; may change at any time.
- `q`  out  WIDTH: synchronised level, the output of the final stage.
- `q_rise`  out  WIDTH: per bit, high for exactly one cycle when `q` goes 0→1.
- `q_fall`  out  WIDTH: per bit, high for exactly one cycle when `q` goes 1→0.

## Operation
- Per bit, the chain is s[0]..s[STAGES-1]. Each cycle: s[0] <= d, s[i] <= s[i-1], q = s[STAGES-1].
- The history register is q_prev <= q each cycle.
- Edge outputs are combinational from registers only:
  - q_rise = q & ~q_prev
  - q_fall = ~q & q_prev
  - They are glitch-free and no logic sits between `d` and s[0].
- Reset, when `rst`=1 at a rising edge:
  - all s[i] <= RESET_VAL and q_prev <= RESET_VAL;
  - `d` is ignored that cycle.
- Outputs after reset: q = RESET_VAL, q_rise = 0, q_fall = 0.
- There is no pulse on reset exit, even if `d` differs from RESET_VAL at that moment. Pulses appear only when the value has propagated to `q`.
- Power-up: every register initialises to RESET_VAL, so the block is usable without asserting `rst`.
- Reset mid-propagation discards in-flight values. The chain restarts from RESET_VAL.
- Apply the ASYNC_REG / synchroniser attribute to all chain flops so the tool keeps them adjacent. This attribute does not apply to q_prev.

## Timing
- Latency: a `d` change that is set up before edge N appears on `q` after edge N+STAGES-1. That is STAGES edges including the capture edge (2 for the default).
- Metastability on the first stage may add one cycle of uncertainty to that latency. Verification checks latency STAGES or STAGES+1 for inputs changing near an edge, and exactly STAGES for inputs stable across the capture edge.
- `q_rise` / `q_fall` assert in the same cycle `q` changes and deassert the next cycle.
- Input pulses: a pulse shorter than one `dest_clk` period may be lost. A pulse held for at least 2 periods is always reproduced on `q`, with width preserved ±1 cycle.
- If `d` toggles on consecutive cycles, `q` reproduces the toggles delayed by STAGES. Rise and fall then alternate on consecutive cycles and are never asserted together on the same bit.
- A reset asserted while an edge is in the pipe: the `q` change does not occur, and no pulse is produced.
- Throughput: one new sample per cycle per bit. There is no handshake.

## Test plan
- Default params, `rst` high 3 cycles then low, `d`=1 held from before the first post-reset edge:
  - q=0 for edges 1..1 after release;
  - q=1 after the 2nd edge, q_rise=1 for that one cycle, q_fall=0 throughout.
- WIDTH=4, STAGES=3: d=4'b1010 then 4'b0101 one cycle later.
  - q shows 1010 three edges after capture, then 0101 one edge later;
  - q_rise=0101 and q_fall=1010 in that second cycle.
- RESET_VAL=1, WIDTH=1: with d=0 during `rst` release, q=1 and no pulses until the 0 propagates.
  - Then q_fall=1 for one cycle, STAGES edges after release.
- Mid-flight reset: d 0→1, then `rst`=1 for one cycle one edge later.
  - q stays 0, q_rise never asserts;
  - after release with d=1, q rises STAGES edges later with a single q_rise pulse.
- Alternating d (0,1,0,1…) each cycle, STAGES=2:
  - q mirrors d delayed by 2;
  - q_rise and q_fall alternate every cycle and are never simultaneously high.
- Random async `d` (changes off-grid, held ≥2 periods), 10k cycles:
  - every change reaches `q` within STAGES+1 edges;
  - exactly one pulse per `q` transition.
